// File: rtl/xnand_gate_pipe.sv
// xnand_gate_pipe: two-stage valid/ready pipeline applying one of eight bitwise gate functions.
// Optional registered parity output is enabled by defining XNAND_PIPE_PARITY_EN.
module xnand_gate_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic [CNT_W-1:0] txn_count
`ifdef XNAND_PIPE_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_NAND  = 3'b010,
        OP_NOR   = 3'b011,
        OP_XOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_XNAND = 3'b110,
        OP_NOTA  = 3'b111
    } op_e;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_e              r_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_zero;
    logic [CNT_W-1:0] r_txn;

    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_c;

    assign w_s2_free  = !r_s2_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    // in_ready is held low while reset is asserted so no beat is taken during reset
    assign in_ready   = rst_n && (!r_s1_valid || w_s2_free);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    always_comb begin
        w_c = '0;
        case (r_op)
            OP_AND:   w_c = r_a & r_b;
            OP_OR:    w_c = r_a | r_b;
            OP_NAND:  w_c = ~(r_a & r_b);
            OP_NOR:   w_c = ~(r_a | r_b);
            OP_XOR:   w_c = r_a ^ r_b;
            OP_XNOR:  w_c = ~(r_a ^ r_b);
            OP_XNAND: w_c = ~(~(r_a ^ r_b));
            OP_NOTA:  w_c = ~r_a;
            default:  w_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_AND;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_a        <= A;
            r_b        <= B;
            r_op       <= op_e'(op);
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_c        <= '0;
            r_zero     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_c        <= w_c;
            r_zero     <= (w_c == '0);
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn <= '0;
        end else if (w_out_fire) begin
            r_txn <= r_txn + CNT_W'(1);
        end
    end

`ifdef XNAND_PIPE_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_s1_adv) begin
            r_parity <= ^w_c;
        end
    end

    assign parity = r_parity;
`endif

    assign out_valid = r_s2_valid;
    assign C         = r_c;
    assign zero      = r_s2_valid && r_zero;
    assign txn_count = r_txn;

endmodule

// File: tb/tb_xnand_gate_pipe.sv
// Directed self-checking bench for xnand_gate_pipe; a second instance with CNT_W=2 checks counter wrap.
module tb_xnand_gate_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  C;
    logic        zero;
    logic [15:0] txn_count;
    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  C2;
    logic        zero2;
    logic [1:0]  txn_count2;
`ifdef XNAND_PIPE_PARITY_EN
    logic        parity;
    logic        parity2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xnand_gate_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .zero(zero), .txn_count(txn_count)
`ifdef XNAND_PIPE_PARITY_EN
        , .parity(parity)
`endif
    );

    xnand_gate_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .A(A), .B(B), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .C(C2), .zero(zero2), .txn_count(txn_count2)
`ifdef XNAND_PIPE_PARITY_EN
        , .parity(parity2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] op_exp  [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h3C, 8'h0F};
    logic [7:0] rf_a    [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    logic [7:0] rf_c    [6] = '{8'h0E, 8'h0D, 8'h0B, 8'h07, 8'h1F, 8'h2F};
    logic [1:0] wrap_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        op        = '0;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_C", C, 0);
        chk("rst_zero", zero, 0);
        chk("rst_txn", txn_count, 0);
`ifdef XNAND_PIPE_PARITY_EN
        chk("rst_parity", parity, 0);
`endif
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();

        // all eight opcodes, A=F0 B=CC
        for (int i = 0; i < 8; i++) begin
            A = 8'hF0; B = 8'hCC; op = 3'(i); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("op%0d_lat1_out_valid", i), out_valid, 0);
            tick();
            chk($sformatf("op%0d_lat2_out_valid", i), out_valid, 1);
            chk($sformatf("op%0d_C", i), C, op_exp[i]);
`ifdef XNAND_PIPE_PARITY_EN
            chk($sformatf("op%0d_parity", i), parity, ^op_exp[i]);
`endif
        end
        tick();
        chk("ops_txn", txn_count, 8);
        chk("ops_out_valid_drained", out_valid, 0);

        // back-to-back then stall
        B = 8'hFF; op = 3'b000; in_valid = 1'b1;
        A = 8'h11; tick();
        chk("b2b_e1_out_valid", out_valid, 0);
        A = 8'h22; tick();
        chk("b2b_e2_C", C, 8'h11);
        chk("b2b_e2_out_valid", out_valid, 1);
        A = 8'h33; tick();
        chk("b2b_e3_C", C, 8'h22);
        chk("b2b_e3_txn", txn_count, 9);
        A = 8'h44; tick();
        chk("b2b_e4_C", C, 8'h33);
        chk("b2b_e4_txn", txn_count, 10);
        out_ready = 1'b0; A = 8'h55;
        #1;
        chk("stall_in_ready_low", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d_C", i), C, 8'h33);
            chk($sformatf("stall%0d_out_valid", i), out_valid, 1);
            chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
            chk($sformatf("stall%0d_txn", i), txn_count, 10);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rel1_C", C, 8'h44);
        chk("rel1_txn", txn_count, 11);
        tick();
        chk("rel2_C", C, 8'h55);
        chk("rel2_txn", txn_count, 12);
        tick();
        chk("rel3_out_valid", out_valid, 0);
        chk("rel3_txn", txn_count, 13);

        // simultaneous accept and refill, XNAND with B=0F
        B = 8'h0F; op = 3'b110;
        for (int k = 0; k < 6; k++) begin
            A = rf_a[k]; in_valid = 1'b1;
            tick();
            chk($sformatf("refill%0d_in_ready", k), in_ready, 1);
            if (k > 0) begin
                chk($sformatf("refill%0d_out_valid", k), out_valid, 1);
                chk($sformatf("refill%0d_C", k), C, rf_c[k-1]);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("refill_last_C", C, rf_c[5]);
        chk("refill_last_out_valid", out_valid, 1);
        tick();
        chk("refill_drain_out_valid", out_valid, 0);
        chk("refill_txn", txn_count, 19);

        // zero flag
        A = 8'hAA; B = 8'hAA; op = 3'b100; in_valid = 1'b1;
        tick();
        op = 3'b101;
        tick();
        in_valid = 1'b0;
        chk("zero_xor_C", C, 8'h00);
        chk("zero_xor_flag", zero, 1);
        tick();
        chk("zero_xnor_C", C, 8'hFF);
        chk("zero_xnor_flag", zero, 0);
        tick();
        chk("zero_drained_flag", zero, 0);
        chk("zero_txn", txn_count, 21);
        chk("w2_txn_mod4", txn_count2, 1);

        // reset mid-flight with two beats buffered
        B = 8'hFF; op = 3'b000; in_valid = 1'b1;
        A = 8'h77; tick();
        A = 8'h66; tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("inflight_out_valid", out_valid, 1);
        chk("inflight_C", C, 8'h77);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_C", C, 0);
        chk("midrst_txn", txn_count, 0);
        chk("midrst_zero", zero, 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst%0d_out_valid", i), out_valid, 0);
        end
        chk("postrst_txn", txn_count, 0);

        // counter wrap on the CNT_W=2 instance
        B = 8'hFF; op = 3'b001;
        for (int t = 0; t < 7; t++) begin
            A = 8'(t); in_valid = (t < 5);
            tick();
            if (t >= 2) chk($sformatf("wrap%0d_txn", t - 2), txn_count2, wrap_exp[t-2]);
        end
        chk("wrap_main_txn", txn_count, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xnand_gate_pipe.md
Name: xnand_gate_pipe

Overview:
- Parametrised, pipelined successor to the single-bit gate primitives.
- Takes two WIDTH-bit operands plus a 3-bit opcode selecting one of eight bitwise gate functions (including XNAND), and returns the registered result.
- Uses a two-stage valid/ready pipeline with a transaction counter, so it can sit directly on streaming datapaths in the lab designs.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the completed-transaction counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  gate select.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- C  output  WIDTH  result.
- zero  output  1  C == 0, qualified by out_valid.
- txn_count  output  CNT_W  count of results accepted downstream.
- parity  output  1  XOR-reduce of C; present only with XNAND_PIPE_PARITY_EN.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous, active-low.
  - On rst_n low, all state clears immediately: s1_valid=0, s2_valid=0, out_valid=0, C=0, zero=0, txn_count=0, parity=0.
  - in_ready=1 combinationally once rst_n is high and stage 1 is empty.
- Opcode map (bitwise over all WIDTH bits):
  - 000 AND
  - 001 OR
  - 010 NAND
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 XNAND, defined as ~(A XNOR B); numerically equal to XOR, kept as a distinct opcode
  - 111 NOT A (B ignored)
- Stage 1 (capture):
  - Registers A, B and op when in_valid && in_ready.
  - Sets s1_valid.
- Stage 2 (compute):
  - Registers C = f(op, A, B), zero, and parity from the stage-1 registers when stage 1 advances.
  - Sets s2_valid; out_valid = s2_valid.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - Stage 1 advances into stage 2 when s1_valid && s2_free.
  - in_ready = !s1_valid || (s1_valid && s2_free), a combinational path from out_ready.
- Throughput and latency:
  - Full throughput: 1 beat/cycle with out_ready held high.
  - Latency 2 cycles from an accepted input edge to out_valid.
- Backpressure:
  - While out_valid && !out_ready, C, zero and parity hold stable.
  - At most 2 beats are buffered; the third beat sees in_ready=0.
- Stage drain:
  - When a stage empties with no new data, its valid clears.
  - Data registers need not clear, but C must not change while out_valid=1 and not accepted.
- Simultaneous accept and refill: on the same cycle, out_valid && out_ready and stage 1 advancing load stage 2 with the new beat; out_valid stays 1.
- Counter:
  - txn_count increments by 1 on each out_valid && out_ready.
  - Wraps modulo 2^CNT_W; no saturation.
- Opcode capture: op is captured with its operands, so opcode changes never affect in-flight beats.
- Reset mid-operation: in-flight beats are discarded, with no output handshake for them.
- No X propagation: out_valid and in_ready are defined at every cycle after reset.

Optional Feature:
- Macro: XNAND_PIPE_PARITY_EN.
- Defined:
  - The parity port exists.
  - parity = ^C, registered in stage 2 alongside C and held under backpressure.
  - parity resets to 0.
- Not defined: the parity port and its register are absent; all other behaviour is identical.

Test Plan:
- All eight opcodes (WIDTH=8, A=0xF0, B=0xCC, out_ready=1):
  - Stimulus: one beat per opcode.
  - Required C: AND 0xC0, OR 0xFC, NAND 0x3F, NOR 0x03, XOR 0x3C, XNOR 0xC3, XNAND 0x3C, NOT 0x0F.
  - Each result appears 2 cycles after its accept.
  - With XNAND_PIPE_PARITY_EN, parity=0 for 0x3C.
- Back-to-back and stall:
  - Stimulus: 4 consecutive beats with out_ready=1, then drive out_ready=0 for 5 cycles.
  - Required: in_ready drops after 2 buffered beats; C holds stable.
  - Required: on releasing out_ready, the remaining beats emerge in order, and txn_count ends at the number of beats accepted downstream.
- Simultaneous accept and refill:
  - Stimulus: out_ready=1 with the pipe full and in_valid=1 each cycle.
  - Required: sustained 1 beat/cycle with no bubbles and out_valid constant 1.
- Zero flag:
  - Stimulus: A=0xAA, B=0xAA, op=XOR.
  - Required: C=0x00 and zero=1.
  - Stimulus: the next beat op=XNOR.
  - Required: C=0xFF and zero=0.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 asynchronously between clock edges with 2 beats in flight.
  - Required: out_valid=0, C=0 and txn_count=0 immediately.
  - Required: after release, no stale beat appears.
- Counter wrap:
  - Stimulus: CNT_W=2 with 5 accepted results.
  - Required: txn_count sequence 1,2,3,0,1.
